timer_dev: RTL and testbench
============================

// Module: timer_dev
// PURPOSE
//  Memory-mapped count-down timer on the mips data bus, downstream of the CPU's aluReg address / bReg store data.
//  CPU programs it with sw and reads it with lw. It raises irq on expiry.
//  One-shot and auto-reload modes are supported.
//  A bus decoder instantiates it beside dm_1k and muxes dout into the load path when addr selects the timer.
// PARAMETERS
//  CNT_W      32  width of PRESET/COUNT registers (<=32; upper dout bits read 0)
//  PRESET_RST 0   reset value of PRESET
// PORTS
//  clk   in   1      clock; all state updates on rising edge
//  rst   in   1      reset; synchronous, active-low (0 = reset on next clk edge)
//  sel   in   1      device selected by bus decoder
//  we    in   1      write strobe (valid only with sel)
//  addr  in   2      word offset = CPU addr[3:2]
//  din   in   32     write data
//  dout  out  32     read data, combinational from addr
//  irq   out  1      interrupt request, registered
// BEHAVIOUR
//  Registers:
//   - addr 0 CTRL: [0] EN, [1] MODE (0 one-shot, 1 auto-reload), [3] IM (irq mask), [4] PEND (read-only).
//   - addr 1 PRESET (rw). addr 2 COUNT (ro; writes ignored). addr 3 reads 0, writes ignored.
//  Reset (rst==0 at edge): CTRL=0, PEND=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq=0. Reset wins over any same-cycle write.
//  Writes take effect at the edge where sel&we are high. Reads are combinational with zero latency.
//  FSM:
//   - IDLE: EN=1 -> LOAD.
//   - LOAD (1 cycle): COUNT<=PRESET -> CNT.
//   - CNT: EN=0 -> IDLE with COUNT held. COUNT>1 -> COUNT-1, stay. COUNT<=1 -> COUNT<=0 -> INT.
//   - INT (1 cycle): PEND<=1. MODE=1 -> LOAD. MODE=0 -> EN<=0 -> IDLE.
//  Latency: PRESET=N>=1 gives EN-write edge -> INT state after N+2 edges. PRESET=0 behaves as PRESET=1 (expires immediately).
//  irq = PEND & IM, registered, so it rises one cycle after INT.
//  PEND is cleared by any CTRL write. If the PEND set and a CTRL write land in the same cycle, set wins (no lost interrupt).
//  CTRL write in the same cycle as INT with MODE=0: the written EN value wins over the auto-clear.
//  PRESET write during CNT does not disturb COUNT; it is used at the next LOAD.
//  CTRL write with EN=1 while in CNT does not restart the count.
//  Counter arithmetic is unsigned CNT_W-bit. No wrap below 0 is possible: the COUNT<=1 check precedes the decrement.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined:
//   - CTRL[15:8] = PS (rw). In CNT, COUNT decrements only on a tick every PS+1 clk cycles.
//   - Prescale counter resets to 0 on LOAD, on EN=0, and on reset.
//   - The INT transition also waits for a tick.
//  TIMER_PRESCALE_EN undefined: CTRL[15:8] reads 0 and writes are ignored; tick is constant 1.
// STRUCTURE
//  Package timer_pkg:
//   - state encoding (IDLE/LOAD/CNT/INT, 2 bits)
//   - register offsets
//   - CTRL bit positions (EN, MODE, IM, PEND, PS field)
//  One sub-module, timer_prescaler (clk, rst, clr, ps[7:0] -> tick), instantiated only under TIMER_PRESCALE_EN.
//  FSM, register file and read mux stay in timer_dev.
// TESTING
//  1. Reset: drive rst=0 for 2 edges with we=1 -> all reads 0, irq=0, state IDLE.
//  2. One-shot: PRESET=5, then CTRL=0x9 (EN,IM).
//     -> COUNT reads 5,4,3,2,1,0; irq=1 on the 8th edge after the CTRL write; EN reads 0.
//     -> A subsequent CTRL write of 0 clears irq.
//  3. Auto-reload: PRESET=3, CTRL=0xB.
//     -> Expiries every 5 cycles; COUNT reloads to 3; PEND stays 1 until a CTRL write.
//  4. Mid-count disable: PRESET=100, EN=1, then EN=0 after 10 cycles.
//     -> COUNT freezes at its value and no irq.
//     -> Re-enable reloads 100.
//  5. Simultaneous: CTRL write in the cycle PEND is set -> PEND reads 1. PRESET=0 -> expires as PRESET=1.
//  6. With TIMER_PRESCALE_EN: PS=3, PRESET=2 -> COUNT decrements every 4 cycles. Without the macro: CTRL[15:8] reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped count-down timer.
// State encoding, register offsets and CTRL bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    localparam int B_EN   = 0;
    localparam int B_MODE = 1;
    localparam int B_IM   = 3;
    localparam int B_PEND = 4;
    localparam int PS_LSB = 8;
    localparam int PS_MSB = 15;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into a one-cycle tick every ps+1 cycles.
// Used by timer_dev only when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [7:0] ps,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    // >= keeps the divider from running the long way round if ps shrinks
    assign tick = (cnt_q >= ps);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped count-down timer with one-shot/auto-reload modes and irq.
// Optional clock prescaler in CTRL[15:8] enabled by TIMER_PRESCALE_EN.
module timer_dev
    import timer_pkg::*;
#(
    parameter int                 CNT_W      = 32,
    parameter logic [CNT_W-1:0]   PRESET_RST = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_e st_q, st_d;
    logic en_q, en_d, mode_q, mode_d, im_q, im_d;
    logic pend_q, pend_d, irq_q, irq_d;
    logic [CNT_W-1:0] preset_q, preset_d, cnt_q, cnt_d;
    logic [7:0] ps_v;
    logic tick, set_pend, wr_ctrl, wr_pre;

    assign wr_ctrl = sel && we && (addr == A_CTRL);
    assign wr_pre  = sel && we && (addr == A_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] ps_q;
    logic ps_clr;

    assign ps_v   = ps_q;
    assign ps_clr = (st_q == S_LOAD) || !en_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_q <= '0;
        end else if (wr_ctrl) begin
            ps_q <= din[PS_MSB:PS_LSB];
        end
    end

    timer_prescaler u_ps (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .ps   (ps_q),
        .tick (tick)
    );
`else
    assign ps_v = '0;
    assign tick = 1'b1;
`endif

    always_comb begin
        st_d     = st_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        set_pend = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (en_q) st_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d = preset_q;
                st_d  = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    st_d = S_IDLE;
                end else if (tick) begin
                    // test before decrement so COUNT never wraps
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        st_d  = S_INT;
                    end
                end
            end
            S_INT: begin
                set_pend = 1'b1;
                if (mode_q) begin
                    st_d = S_LOAD;
                end else begin
                    en_d = 1'b0;
                    st_d = S_IDLE;
                end
            end
        endcase
        if (wr_ctrl) begin
            en_d   = din[B_EN];
            mode_d = din[B_MODE];
            im_d   = din[B_IM];
            pend_d = 1'b0;
        end
        if (set_pend) pend_d = 1'b1;
        if (wr_pre) preset_d = din[CNT_W-1:0];
        irq_d = pend_d && im_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q     <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            cnt_q    <= '0;
            preset_q <= PRESET_RST;
        end else begin
            st_q     <= st_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
        end
    end

    always_comb begin
        dout = '0;
        unique case (addr)
            A_CTRL: begin
                dout[B_EN]          = en_q;
                dout[B_MODE]        = mode_q;
                dout[B_IM]          = im_q;
                dout[B_PEND]        = pend_q;
                dout[PS_MSB:PS_LSB] = ps_v;
            end
            A_PRESET: dout[CNT_W-1:0] = preset_q;
            A_COUNT:  dout[CNT_W-1:0] = cnt_q;
            A_RSVD:   dout = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized bench for timer_dev; expected values come from timeline
// arithmetic (N+2 edges to expiry, period N+2, PS+1 divider).
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF0A;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_000A;
`endif

    timer_dev #(.CNT_W(32), .PRESET_RST(32'd0)) dut (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        step();
        sel = 1'b0; we = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic quiesce();
        wr(2'd0, 32'h0);
        repeat (4) step();
        wr(2'd0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0; sel = 1'b1; we = 1'b1;
        addr = 2'd1; din = $urandom;
        step();
        addr = 2'd0; din = $urandom | 32'h1;
        step();
        rst = 1'b1; sel = 1'b0; we = 1'b0; din = '0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read a=%0d got %0h want 0", a, v);
            end
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
        repeat (3) step();
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL reset_idle_count got %0h want 0", v);
        end
    endtask

    task automatic test_regs();
        logic [31:0] v, p, c;
        p = $urandom;
        wr(2'd1, p);
        rd(2'd1, v);
        n_cmp++;
        if (v !== p) begin
            n_err++;
            $display("FAIL preset_rw got %0h want %0h", v, p);
        end
        wr(2'd2, $urandom);
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL count_ro got %0h want 0", v);
        end
        wr(2'd3, $urandom);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL rsvd_read got %0h want 0", v);
        end
        for (int i = 0; i < 3; i++) begin
            c = $urandom & 32'hFFFF_FFFE;
            wr(2'd0, c);
            rd(2'd0, v);
            n_cmp++;
            if (v !== (c & CTRL_MASK)) begin
                n_err++;
                $display("FAIL ctrl_rw got %0h want %0h", v, c & CTRL_MASK);
            end
        end
        wr(2'd0, 32'hFF0A);
        rd(2'd0, v);
        n_cmp++;
        if (v !== (32'hFF0A & CTRL_MASK)) begin
            n_err++;
            $display("FAIL ctrl_ps_field got %0h want %0h", v, 32'hFF0A & CTRL_MASK);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_oneshot(input int n, input int im);
        logic [31:0] v;
        logic exi;
        int ne, ex;
        ne = (n == 0) ? 1 : n;
        wr(2'd1, 32'(n));
        wr(2'd0, 32'(1 | (im << 3)));
        for (int k = 1; k <= ne + 3; k++) begin
            step();
            if (k >= 2) begin
                rd(2'd2, v);
                ex = (k - 2 < n) ? n - (k - 2) : 0;
                n_cmp++;
                if (v !== 32'(ex)) begin
                    n_err++;
                    $display("FAIL oneshot_count n=%0d k=%0d got %0d want %0d", n, k, v, ex);
                end
            end
            rd(2'd0, v);
            ex = (k < ne + 3) ? (1 | (im << 3)) : ((im << 3) | 16);
            n_cmp++;
            if (v !== 32'(ex)) begin
                n_err++;
                $display("FAIL oneshot_ctrl n=%0d k=%0d got %0h want %0h", n, k, v, ex);
            end
            exi = (k == ne + 3) && (im != 0);
            n_cmp++;
            if (irq !== exi) begin
                n_err++;
                $display("FAIL oneshot_irq n=%0d k=%0d got %b want %b", n, k, irq, exi);
            end
        end
        wr(2'd0, 32'h0);
        rd(2'd0, v);
        n_cmp++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_clear ctrl=%0h irq=%b want 0/0", v, irq);
        end
    endtask

    task automatic test_autoreload(input int n);
        logic [31:0] v;
        int ne, per, j, ex;
        logic pe;
        ne  = (n == 0) ? 1 : n;
        per = ne + 2;
        wr(2'd1, 32'(n));
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 2 + 3 * per; k++) begin
            step();
            pe = (k >= ne + 3);
            if (k >= 2) begin
                j  = (k - 2) % per;
                ex = (j < n) ? n - j : 0;
                rd(2'd2, v);
                n_cmp++;
                if (v !== 32'(ex)) begin
                    n_err++;
                    $display("FAIL auto_count n=%0d k=%0d got %0d want %0d", n, k, v, ex);
                end
            end
            rd(2'd0, v);
            n_cmp++;
            if (v !== (32'hB | (pe ? 32'h10 : 32'h0)) || irq !== pe) begin
                n_err++;
                $display("FAIL auto_pend n=%0d k=%0d ctrl=%0h irq=%b want pend=%b", n, k, v, irq, pe);
            end
        end
        quiesce();
        rd(2'd0, v);
        n_cmp++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL auto_stop ctrl=%0h irq=%b want 0/0", v, irq);
        end
    endtask

    task automatic test_disable(input int n, input int d);
        logic [31:0] v;
        int fz;
        wr(2'd1, 32'(n));
        wr(2'd0, 32'h9);
        for (int k = 1; k < d; k++) step();
        wr(2'd0, 32'h8);
        fz = n - (d - 2);
        for (int i = 0; i < 5; i++) begin
            rd(2'd2, v);
            n_cmp++;
            if (v !== 32'(fz)) begin
                n_err++;
                $display("FAIL disable_freeze i=%0d got %0d want %0d", i, v, fz);
            end
            rd(2'd0, v);
            n_cmp++;
            if (v !== 32'h8 || irq !== 1'b0) begin
                n_err++;
                $display("FAIL disable_noirq ctrl=%0h irq=%b want 8/0", v, irq);
            end
            step();
        end
        wr(2'd0, 32'h9);
        step();
        step();
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'(n)) begin
            n_err++;
            $display("FAIL disable_reload got %0d want %0d", v, n);
        end
        quiesce();
    endtask

    task automatic test_simul(input int n);
        logic [31:0] v;
        int ne;
        ne = (n == 0) ? 1 : n;
        wr(2'd1, 32'(n));
        wr(2'd0, 32'h1);
        for (int k = 1; k <= ne + 2; k++) step();
        wr(2'd0, 32'h9);
        rd(2'd0, v);
        n_cmp++;
        if (v !== 32'h19 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL simul_pend n=%0d ctrl=%0h irq=%b want 19/1", n, v, irq);
        end
        step();
        step();
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'(n)) begin
            n_err++;
            $display("FAIL simul_restart n=%0d got %0d want %0d", n, v, n);
        end
        quiesce();
    endtask

    task automatic test_midwrite(input int n, input int m);
        logic [31:0] v;
        wr(2'd1, 32'(n));
        wr(2'd0, 32'hB);
        step();
        step();
        wr(2'd1, 32'(m));
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'(n - 1)) begin
            n_err++;
            $display("FAIL mid_preset_keep got %0d want %0d", v, n - 1);
        end
        step();
        wr(2'd0, 32'hB);
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'(n - 3)) begin
            n_err++;
            $display("FAIL mid_en_norestart got %0d want %0d", v, n - 3);
        end
        for (int k = 6; k <= n + 4; k++) step();
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'(m)) begin
            n_err++;
            $display("FAIL mid_new_preset got %0d want %0d", v, m);
        end
        rd(2'd0, v);
        n_cmp++;
        if (v !== 32'h1B) begin
            n_err++;
            $display("FAIL mid_ctrl got %0h want 1b", v);
        end
        quiesce();
    endtask

    task automatic test_reset_wins();
        logic [31:0] v;
        wr(2'd1, 32'd50);
        wr(2'd0, 32'h9);
        repeat (5) step();
        rst = 1'b0; sel = 1'b1; we = 1'b1; addr = 2'd0; din = 32'h9;
        step();
        rst = 1'b1; sel = 1'b0; we = 1'b0; din = '0;
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_err++;
                $display("FAIL rstwin_read a=%0d got %0h want 0", a, v);
            end
        end
        repeat (3) step();
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL rstwin_idle count=%0h irq=%b want 0/0", v, irq);
        end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale(input int ps, input int n);
        logic [31:0] v;
        int ne, tot, ex;
        logic exi;
        ne  = (n == 0) ? 1 : n;
        tot = ne * (ps + 1) + 3;
        wr(2'd1, 32'(n));
        wr(2'd0, 32'((ps << 8) | 9));
        for (int k = 1; k <= tot; k++) begin
            step();
            if (k >= 2) begin
                ex = n - (k - 2) / (ps + 1);
                if (ex < 0) ex = 0;
                rd(2'd2, v);
                n_cmp++;
                if (v !== 32'(ex)) begin
                    n_err++;
                    $display("FAIL ps_count ps=%0d n=%0d k=%0d got %0d want %0d", ps, n, k, v, ex);
                end
            end
            exi = (k == tot);
            n_cmp++;
            if (irq !== exi) begin
                n_err++;
                $display("FAIL ps_irq ps=%0d n=%0d k=%0d got %b want %b", ps, n, k, irq, exi);
            end
        end
        quiesce();
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_oneshot(5, 1);
        test_oneshot(0, 1);
        for (int i = 0; i < 4; i++) begin
            test_oneshot(int'($urandom_range(0, 12)), int'($urandom_range(0, 1)));
        end
        test_autoreload(3);
        for (int i = 0; i < 3; i++) begin
            test_autoreload(int'($urandom_range(0, 6)));
        end
        test_disable(100, 12);
        test_disable(int'($urandom_range(40, 120)), int'($urandom_range(3, 30)));
        for (int i = 0; i < 3; i++) begin
            test_simul(int'($urandom_range(0, 6)));
        end
        for (int i = 0; i < 2; i++) begin
            test_midwrite(int'($urandom_range(6, 20)), int'($urandom_range(1, 20)));
        end
`ifdef TIMER_PRESCALE_EN
        test_prescale(3, 2);
        for (int i = 0; i < 3; i++) begin
            test_prescale(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
`endif
        test_reset_wins();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
